// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: round-robin sharing of one sys_bus master port between MN
// requesters. Each requester's one-cycle wen/ren strobe is latched into a
// pending slot, one transaction is issued at a time, and the completion
// (ack/err/rdata) is routed back to the owning requester. A cycle counter
// terminates transactions that no slave ever acknowledges.

// Protocol invariants on the arbiter's own outputs.
module sys_bus_arbiter_chk #(
  parameter int MN = 4
) (
  input logic          clk,
  input logic          rst,
  input logic          bus_wen,
  input logic          bus_ren,
  input logic [MN-1:0] req_ack,
  input logic [MN-1:0] req_err
);

  // Check one-strobe-at-a-time, one-hot completion and err qualified by ack.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(bus_wen && bus_ren));
      assert ($onehot0(req_ack));
      assert ((req_err & ~req_ack) == '0);
    end
  end

endmodule

module sys_bus_arbiter #(
  parameter  int MN = 4,
  parameter  int AW = 32,
  parameter  int DW = 32,
  parameter  int TO = 255,
  localparam int ML = $clog2(MN),
  localparam int CW = $clog2(TO + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [MN-1:0][AW-1:0] req_addr_i,
  input  logic [MN-1:0][DW-1:0] req_wdata_i,
  input  logic [MN-1:0]        req_wen_i,
  input  logic [MN-1:0]        req_ren_i,
  output logic [MN-1:0][DW-1:0] req_rdata_o,
  output logic [MN-1:0]        req_ack_o,
  output logic [MN-1:0]        req_err_o,
  output logic [MN-1:0]        req_ovf_o,
  output logic [AW-1:0]        bus_addr_o,
  output logic [DW-1:0]        bus_wdata_o,
  output logic                 bus_wen_o,
  output logic                 bus_ren_o,
  input  logic [DW-1:0]        bus_rdata_i,
  input  logic                 bus_ack_i,
  input  logic                 bus_err_i,
  output logic                 busy_o,
  output logic [ML-1:0]        grant_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               state_r;
  logic [MN-1:0]        pend_r;
  logic [MN-1:0]        op_wr_r;
  logic [MN-1:0][AW-1:0] addr_r;
  logic [MN-1:0][DW-1:0] wdata_r;
  logic [ML-1:0]        rr_ptr_r;
  logic [CW-1:0]        cnt_r;

  logic [MN-1:0]        strobe_s;
  logic [MN-1:0]        clr_s;
  logic [MN-1:0]        accept_s;
  logic [MN-1:0]        drop_s;
  logic [ML-1:0]        pick_s;
  logic [MN-1:0]        grant_hot_s;

  // First set bit of p scanning upward from ptr, wrapping modulo MN.
  function automatic logic [ML-1:0] rr_pick(input logic [MN-1:0] p,
                                            input logic [ML-1:0] ptr);
    int   idx;
    logic found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < MN; k++) begin
      idx = int'(ptr) + k;
      if (idx >= MN) begin
        idx = idx - MN;
      end
      if (!found && p[ML'(idx)]) begin
        found   = 1'b1;
        rr_pick = ML'(idx);
      end
    end
  endfunction

  // (g + 1) mod MN, valid for non-power-of-two MN as well.
  function automatic logic [ML-1:0] next_idx(input logic [ML-1:0] g);
    if (g == ML'(MN - 1)) begin
      next_idx = '0;
    end else begin
      next_idx = g + ML'(1);
    end
  endfunction

  // Index to one-hot requester vector.
  function automatic logic [MN-1:0] one_hot(input logic [ML-1:0] g);
    one_hot    = '0;
    one_hot[g] = 1'b1;
  endfunction

  assign strobe_s    = req_wen_i | req_ren_i;
  assign grant_hot_s = one_hot(grant_o);
  assign pick_s      = rr_pick(pend_r, rr_ptr_r);

  // Pending-slot clear for the requester completing this cycle; a new strobe
  // from that same requester is accepted because set wins over clear.
  always_comb begin
    clr_s    = '0;
    accept_s = '0;
    drop_s   = '0;
    if (state_r == ST_DONE) begin
      clr_s = grant_hot_s;
    end else begin
      clr_s = '0;
    end
    accept_s = strobe_s & (~pend_r | clr_s);
    drop_s   = strobe_s & pend_r & ~clr_s;
  end

  // Capture strobes into pending slots and record dropped strobes as overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_r    <= '0;
      req_ovf_o <= '0;
      op_wr_r   <= '0;
      addr_r    <= '0;
      wdata_r   <= '0;
    end else begin
      pend_r    <= (pend_r & ~clr_s) | accept_s;
      req_ovf_o <= req_ovf_o | drop_s;
      for (int i = 0; i < MN; i++) begin
        if (accept_s[i]) begin
          addr_r[i]  <= req_addr_i[i];
          wdata_r[i] <= req_wdata_i[i];
          op_wr_r[i] <= req_wen_i[i];
        end
      end
    end
  end

  // Transaction sequencer: grant, issue strobe, wait/timeout, report back.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      grant_o     <= '0;
      cnt_r       <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_wen_o   <= 1'b0;
      bus_ren_o   <= 1'b0;
      req_ack_o   <= '0;
      req_err_o   <= '0;
      req_rdata_o <= '0;
      busy_o      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|pend_r) begin
            grant_o     <= pick_s;
            bus_addr_o  <= addr_r[pick_s];
            bus_wdata_o <= wdata_r[pick_s];
            bus_wen_o   <= op_wr_r[pick_s];
            bus_ren_o   <= ~op_wr_r[pick_s];
            busy_o      <= 1'b1;
            state_r     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          bus_wen_o <= 1'b0;
          bus_ren_o <= 1'b0;
          cnt_r     <= '0;
          state_r   <= ST_WAIT;
        end
        ST_WAIT: begin
          // An ack in the same cycle the counter hits TO still wins.
          if (bus_ack_i) begin
            req_ack_o            <= grant_hot_s;
            req_err_o            <= bus_err_i ? grant_hot_s : '0;
            req_rdata_o[grant_o] <= bus_rdata_i;
            state_r              <= ST_DONE;
          end else if (cnt_r == CW'(TO)) begin
            req_ack_o <= grant_hot_s;
            req_err_o <= grant_hot_s;
            state_r   <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DONE: begin
          req_ack_o   <= '0;
          req_err_o   <= '0;
          req_rdata_o <= '0;
          rr_ptr_r    <= next_idx(grant_o);
          busy_o      <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          bus_wen_o   <= 1'b0;
          bus_ren_o   <= 1'b0;
          req_ack_o   <= '0;
          req_err_o   <= '0;
          req_rdata_o <= '0;
          busy_o      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  sys_bus_arbiter_chk #(
    .MN(MN)
  ) u_chk (
    .clk     (clk_i),
    .rst     (rst_i),
    .bus_wen (bus_wen_o),
    .bus_ren (bus_ren_o),
    .req_ack (req_ack_o),
    .req_err (req_err_o)
  );

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Scoreboard bench for sys_bus_arbiter (MN=4, TO=8): stimulus pushes the
// expected bus strobes and requester completions; monitors pop and compare.
module tb_sys_bus_arbiter;

  localparam int MN = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  typedef struct {
    int          cyc;
    logic [1:0]  grant;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
  } bus_exp_t;

  typedef struct {
    int          cyc;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [31:0] rdata;
  } ack_exp_t;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic [MN-1:0][AW-1:0] req_addr_i;
  logic [MN-1:0][DW-1:0] req_wdata_i;
  logic [MN-1:0]         req_wen_i;
  logic [MN-1:0]         req_ren_i;
  logic [MN-1:0][DW-1:0] req_rdata_o;
  logic [MN-1:0]         req_ack_o;
  logic [MN-1:0]         req_err_o;
  logic [MN-1:0]         req_ovf_o;
  logic [AW-1:0]         bus_addr_o;
  logic [DW-1:0]         bus_wdata_o;
  logic                  bus_wen_o;
  logic                  bus_ren_o;
  logic [DW-1:0]         bus_rdata_i;
  logic                  bus_ack_i;
  logic                  bus_err_i;
  logic                  busy_o;
  logic [1:0]            grant_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bus_exp_t bus_q[$];
  ack_exp_t ack_q[$];

  // slave model controls
  int          slave_lat   = 1;
  logic [31:0] slave_rdata = 32'h0;
  logic        slave_err   = 1'b0;
  int          ack_at      = -1;
  int          stray_at    = -1;

  logic [31:0] fa [4];
  logic [31:0] fw [4];

  sys_bus_arbiter #(.MN(MN), .AW(AW), .DW(DW), .TO(TO)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_wen_i   (req_wen_i),
    .req_ren_i   (req_ren_i),
    .req_rdata_o (req_rdata_o),
    .req_ack_o   (req_ack_o),
    .req_err_o   (req_err_o),
    .req_ovf_o   (req_ovf_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_wen_o   (bus_wen_o),
    .bus_ren_o   (bus_ren_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ack_i   (bus_ack_i),
    .bus_err_i   (bus_err_i),
    .busy_o      (busy_o),
    .grant_o     (grant_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bus(input int c, input logic [1:0] g, input logic [31:0] a,
                          input logic [31:0] w, input logic wen);
    bus_exp_t e;
    e.cyc = c; e.grant = g; e.addr = a; e.wdata = w; e.wen = wen;
    bus_q.push_back(e);
  endtask

  task automatic push_ack(input int c, input logic [3:0] a, input logic [3:0] er,
                          input logic [31:0] rd);
    ack_exp_t e;
    e.cyc = c; e.ack = a; e.err = er; e.rdata = rd;
    ack_q.push_back(e);
  endtask

  task automatic clear_strobes();
    req_wen_i = '0;
    req_ren_i = '0;
  endtask

  task automatic chk_reset_state(input string tag);
    check({tag, "_bus_addr"},  128'(bus_addr_o),  128'(0));
    check({tag, "_bus_wdata"}, 128'(bus_wdata_o), 128'(0));
    check({tag, "_bus_wen"},   128'(bus_wen_o),   128'(0));
    check({tag, "_bus_ren"},   128'(bus_ren_o),   128'(0));
    check({tag, "_req_ack"},   128'(req_ack_o),   128'(0));
    check({tag, "_req_err"},   128'(req_err_o),   128'(0));
    check({tag, "_req_rdata"}, 128'(req_rdata_o), 128'(0));
    check({tag, "_req_ovf"},   128'(req_ovf_o),   128'(0));
    check({tag, "_busy"},      128'(busy_o),      128'(0));
    check({tag, "_grant"},     128'(grant_o),     128'(0));
  endtask

  task automatic drain();
    int n = 0;
    while ((bus_q.size() != 0 || ack_q.size() != 0 || busy_o) && n < 200) begin
      tick();
      n++;
    end
    check("drain_bound", 128'(n >= 200), 128'(0));
    tick();
    tick();
  endtask

  // Slave: drives ack at the scheduled cycle (or a stray one), data/err always.
  initial begin
    bus_ack_i   = 1'b0;
    bus_err_i   = 1'b0;
    bus_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      bus_ack_i   = (cyc == ack_at) || (cyc == stray_at);
      bus_err_i   = slave_err;
      bus_rdata_i = slave_rdata;
    end
  end

  // Bus-side monitor: every issue strobe must match the next expected one.
  always @(negedge clk) begin
    bus_exp_t be;
    if (bus_wen_o || bus_ren_o) begin
      ack_at = (slave_lat > 0) ? cyc + slave_lat : -1;
      if (bus_q.size() == 0) begin
        check("bus_unexpected", 128'({bus_wen_o, bus_ren_o}), 128'(0));
      end else begin
        be = bus_q.pop_front();
        check("bus_cycle", 128'(cyc), 128'(be.cyc));
        check("bus_grant", 128'(grant_o), 128'(be.grant));
        check("bus_addr", 128'(bus_addr_o), 128'(be.addr));
        check("bus_op", 128'({bus_wen_o, bus_ren_o}), 128'({be.wen, ~be.wen}));
        if (be.wen) check("bus_wdata", 128'(bus_wdata_o), 128'(be.wdata));
      end
    end
  end

  // Requester-side monitor: every completion must match the next expected one.
  always @(negedge clk) begin
    ack_exp_t ae;
    logic [MN-1:0][DW-1:0] exp_rd;
    if (req_ack_o != '0) begin
      if (ack_q.size() == 0) begin
        check("ack_unexpected", 128'(req_ack_o), 128'(0));
      end else begin
        ae = ack_q.pop_front();
        for (int i = 0; i < MN; i++) exp_rd[i] = ae.ack[i] ? ae.rdata : 32'h0;
        check("ack_cycle", 128'(cyc), 128'(ae.cyc));
        check("ack_vec", 128'(req_ack_o), 128'(ae.ack));
        check("ack_err", 128'(req_err_o), 128'(ae.err));
        check("ack_rdata", 128'(req_rdata_o), 128'(exp_rd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_i       = 1'b1;
    req_addr_i  = '0;
    req_wdata_i = '0;
    clear_strobes();
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk_reset_state("rst0");

    // Round-robin: all four at once from rr_ptr=0, serve 0,1,2,3
    fa[0] = 32'h0000_0100; fa[1] = 32'h0000_0104; fa[2] = 32'h0000_0108; fa[3] = 32'h0000_010C;
    fw[0] = 32'hA000_0000; fw[1] = 32'hA000_0001; fw[2] = 32'hA000_0002; fw[3] = 32'hA000_0003;
    slave_lat = 1; slave_rdata = 32'h1234_5678; slave_err = 1'b0;
    tick();
    t = cyc;
    for (int k = 0; k < 4; k++) begin
      req_addr_i[k]  = fa[k];
      req_wdata_i[k] = fw[k];
    end
    req_wen_i = 4'b0101;
    req_ren_i = 4'b1010;
    push_bus(t + 2,  2'd0, 32'h0000_0100, 32'hA000_0000, 1'b1);
    push_bus(t + 6,  2'd1, 32'h0000_0104, 32'hA000_0001, 1'b0);
    push_bus(t + 10, 2'd2, 32'h0000_0108, 32'hA000_0002, 1'b1);
    push_bus(t + 14, 2'd3, 32'h0000_010C, 32'hA000_0003, 1'b0);
    push_ack(t + 4,  4'b0001, 4'b0000, 32'h1234_5678);
    push_ack(t + 8,  4'b0010, 4'b0000, 32'h1234_5678);
    push_ack(t + 12, 4'b0100, 4'b0000, 32'h1234_5678);
    push_ack(t + 16, 4'b1000, 4'b0000, 32'h1234_5678);
    tick();
    clear_strobes();
    drain();

    // Second round: only req 0 and req 3, served 0 then 3
    t = cyc;
    req_addr_i[0] = 32'h0000_0200; req_wdata_i[0] = 32'hAAAA_0000; req_wen_i[0] = 1'b1;
    req_addr_i[3] = 32'h0000_0300; req_ren_i[3] = 1'b1;
    push_bus(t + 2, 2'd0, 32'h0000_0200, 32'hAAAA_0000, 1'b1);
    push_bus(t + 6, 2'd3, 32'h0000_0300, 32'h0, 1'b0);
    push_ack(t + 4, 4'b0001, 4'b0000, 32'h1234_5678);
    push_ack(t + 8, 4'b1000, 4'b0000, 32'h1234_5678);
    tick();
    clear_strobes();
    drain();

    // Single read from req 2
    slave_lat = 1; slave_rdata = 32'hDEAD_BEEF; slave_err = 1'b0;
    t = cyc;
    req_addr_i[2] = 32'h0010_0004; req_ren_i[2] = 1'b1;
    push_bus(t + 2, 2'd2, 32'h0010_0004, 32'h0, 1'b0);
    push_ack(t + 4, 4'b0100, 4'b0000, 32'hDEAD_BEEF);
    tick();
    clear_strobes();
    check("rd_busy_t1", 128'(busy_o), 128'(0));
    tick();
    check("rd_busy_t2", 128'(busy_o), 128'(1));
    check("rd_grant_t2", 128'(grant_o), 128'(2));
    tick();
    check("rd_busy_t3", 128'(busy_o), 128'(1));
    tick();
    check("rd_busy_t4", 128'(busy_o), 128'(1));
    tick();
    check("rd_busy_t5", 128'(busy_o), 128'(0));
    drain();

    // Timeout: write never acked; err at strobe+10, stray ack 2 cycles later
    slave_lat = 0; slave_rdata = 32'hBAD0_BAD0; slave_err = 1'b0;
    t = cyc;
    req_addr_i[1] = 32'hDEAD_0000; req_wdata_i[1] = 32'h5555_5555; req_wen_i[1] = 1'b1;
    push_bus(t + 2, 2'd1, 32'hDEAD_0000, 32'h5555_5555, 1'b1);
    push_ack(t + 12, 4'b0010, 4'b0010, 32'h0);
    stray_at = t + 14;
    tick();
    clear_strobes();
    drain();
    while (cyc <= stray_at + 2) tick();

    // Overflow, dropped data, and set-wins in the DONE cycle
    slave_lat = 2; slave_rdata = 32'h0BAD_F00D; slave_err = 1'b0;
    t = cyc;
    req_addr_i[1] = 32'h0000_1000; req_wdata_i[1] = 32'h1111_1111; req_wen_i[1] = 1'b1;
    push_bus(t + 2, 2'd1, 32'h0000_1000, 32'h1111_1111, 1'b1);
    push_ack(t + 5, 4'b0010, 4'b0000, 32'h0BAD_F00D);
    push_bus(t + 7, 2'd1, 32'h0000_4000, 32'h4444_4444, 1'b1);
    push_ack(t + 10, 4'b0010, 4'b0000, 32'h0BAD_F00D);
    tick();
    check("ovf_before_drop", 128'(req_ovf_o), 128'(0));
    req_addr_i[1] = 32'h0000_2000; req_wdata_i[1] = 32'h2222_2222;
    tick();
    check("ovf_after_drop", 128'(req_ovf_o), 128'(4'b0010));
    req_addr_i[1] = 32'h0000_3000; req_wdata_i[1] = 32'h3333_3333;
    tick();
    clear_strobes();
    tick();
    tick();
    req_addr_i[1] = 32'h0000_4000; req_wdata_i[1] = 32'h4444_4444; req_wen_i[1] = 1'b1;
    tick();
    clear_strobes();
    drain();
    check("ovf_sticky", 128'(req_ovf_o), 128'(4'b0010));

    // Ack with err in the very cycle the counter reaches TO
    slave_lat = TO + 1; slave_rdata = 32'hFEED_F00D; slave_err = 1'b1;
    t = cyc;
    req_addr_i[2] = 32'h0000_0ABC; req_ren_i[2] = 1'b1;
    push_bus(t + 2, 2'd2, 32'h0000_0ABC, 32'h0, 1'b0);
    push_ack(t + 12, 4'b0100, 4'b0100, 32'hFEED_F00D);
    tick();
    clear_strobes();
    drain();

    // Reset during WAIT, late ack ignored, next grant scans from 0
    slave_lat = 0; slave_rdata = 32'h7777_7777; slave_err = 1'b0;
    t = cyc;
    req_addr_i[3] = 32'h0000_0333; req_ren_i[3] = 1'b1;
    push_bus(t + 2, 2'd3, 32'h0000_0333, 32'h0, 1'b0);
    tick();
    clear_strobes();
    tick();
    tick();
    tick();
    check("rst_busy_before", 128'(busy_o), 128'(1));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    stray_at = t + 6;
    chk_reset_state("rst1");
    while (cyc <= t + 9) tick();
    slave_lat = 1;
    t = cyc;
    req_addr_i[1] = 32'h0000_0111; req_wdata_i[1] = 32'h1010_1010; req_wen_i[1] = 1'b1;
    req_addr_i[3] = 32'h0000_0333; req_ren_i[3] = 1'b1;
    push_bus(t + 2, 2'd1, 32'h0000_0111, 32'h1010_1010, 1'b1);
    push_bus(t + 6, 2'd3, 32'h0000_0333, 32'h0, 1'b0);
    push_ack(t + 4, 4'b0010, 4'b0000, 32'h7777_7777);
    push_ack(t + 8, 4'b1000, 4'b0000, 32'h7777_7777);
    tick();
    clear_strobes();
    drain();

    check("bus_q_empty", 128'(bus_q.size()), 128'(0));
    check("ack_q_empty", 128'(ack_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
